// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and counter sizing.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        SUB_IDLE = 2'd0,
        SUB_RUN  = 2'd1,
        SUB_DONE = 2'd2
    } sub_state_t;

    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus of the serial subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (output start, a, b, input busy, done, diff, bout, ovf);
    modport slave  (input start, a, b, output busy, done, diff, bout, ovf);
`else
    modport master (output start, a, b, input busy, done, diff, bout);
    modport slave  (input start, a, b, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_subtractor_fullsubtractor.sv
// Single-bit full subtractor cell, the borrow-direction twin of the full-adder cell.
module fullsubtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first a - b using one full-subtractor cell and a borrow flop.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CNT_W = cnt_width(WIDTH);

    localparam logic [1:0] ST_IDLE = SUB_IDLE;
    localparam logic [1:0] ST_RUN  = SUB_RUN;
    localparam logic [1:0] ST_DONE = SUB_DONE;

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sd;
    logic [WIDTH-1:0] sd_next;
    logic             br;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;
    logic             d;
    logic             bo;
    logic             last_bit;

    fullsubtractor u_fs (
        .x  (sa[0]),
        .y  (sb[0]),
        .bi (br),
        .d  (d),
        .bo (bo)
    );

    // New bit enters at the MSB; after WIDTH shifts the LSB lands at bit 0.
    assign sd_next  = WIDTH'({d, sd} >> 1);
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

`ifdef SERIAL_SUB_OVF_EN
    logic am;
    logic bm;
    logic ovf_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            am    <= 1'b0;
            bm    <= 1'b0;
            ovf_r <= 1'b0;
        end else if (state != ST_RUN) begin
            if (bus.start) begin
                am <= bus.a[WIDTH-1];
                bm <= bus.b[WIDTH-1];
            end
        end else if (last_bit) begin
            ovf_r <= (am != bm) && (d != am);
        end
    end

    assign bus.ovf = ovf_r;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            sa     <= '0;
            sb     <= '0;
            sd     <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff_r <= '0;
            bout_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        sa    <= bus.a;
                        sb    <= bus.b;
                        sd    <= '0;
                        br    <= 1'b0;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    br  <= bo;
                    sd  <= sd_next;
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    cnt <= cnt + 1'b1;
                    if (last_bit) begin
                        diff_r <= sd_next;
                        bout_r <= bo;
                        state  <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = (state == ST_RUN);
    assign bus.done = (state == ST_DONE);
    assign bus.diff = diff_r;
    assign bus.bout = bout_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8 scenarios plus exhaustive WIDTH=4 sweep).
// Overflow checks are compiled in when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(4)) bus4 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents operands with start for exactly one sampling edge.
    task automatic start8(input logic [7:0] av, input logic [7:0] bv);
        bus8.a = av;
        bus8.b = bv;
        bus8.start = 1'b1;
        step();
        bus8.start = 1'b0;
    endtask

    task automatic wait_done8(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            n++;
            if (bus8.done === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus8.a = 8'h5A;
        bus8.b = 8'h23;
        bus8.start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({bus8.busy, bus8.done, bus8.diff, bus8.bout} !== 11'd0) begin
                errors++;
                $display("FAIL reset_outputs edge %0d: busy=%b done=%b diff=%h bout=%b, required all 0",
                         i, bus8.busy, bus8.done, bus8.diff, bus8.bout);
            end
`ifdef SERIAL_SUB_OVF_EN
            checks++;
            if (bus8.ovf !== 1'b0) begin
                errors++;
                $display("FAIL reset_ovf: got %b, required 0", bus8.ovf);
            end
`endif
        end
        bus8.start = 1'b0;
        rst_n = 1'b1;
        step();
        checks++;
        if (bus8.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy: got %b, required 0", bus8.busy);
        end
    endtask

    task automatic test_basic();
        start8(8'h5A, 8'h23);
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i < 8) begin
                checks++;
                if ({bus8.busy, bus8.done} !== 2'b10) begin
                    errors++;
                    $display("FAIL basic_running edge E+%0d: busy=%b done=%b, required busy=1 done=0",
                             i, bus8.busy, bus8.done);
                end
            end
            if (i == 4) begin
                checks++;
                if (bus8.diff !== 8'h00) begin
                    errors++;
                    $display("FAIL basic_partial_hidden: diff=%h, required 00", bus8.diff);
                end
            end
        end
        checks++;
        if ({bus8.busy, bus8.done} !== 2'b01) begin
            errors++;
            $display("FAIL basic_done_edge: busy=%b done=%b, required busy=0 done=1", bus8.busy, bus8.done);
        end
        checks++;
        if ({bus8.diff, bus8.bout} !== {8'h37, 1'b0}) begin
            errors++;
            $display("FAIL basic_result: diff=%h bout=%b, required diff=37 bout=0", bus8.diff, bus8.bout);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (bus8.ovf !== 1'b0) begin
            errors++;
            $display("FAIL basic_ovf: got %b, required 0", bus8.ovf);
        end
`endif
        step();
        checks++;
        if ({bus8.done, bus8.diff} !== {1'b0, 8'h37}) begin
            errors++;
            $display("FAIL basic_done_pulse: done=%b diff=%h, required done=0 diff=37", bus8.done, bus8.diff);
        end
    endtask

    task automatic test_borrow_ovf();
        int n;
        start8(8'h00, 8'h01);
        wait_done8(n);
        checks++;
        if ({n[7:0], bus8.diff, bus8.bout} !== {8'd8, 8'hFF, 1'b1}) begin
            errors++;
            $display("FAIL borrow_wrap: edges=%0d diff=%h bout=%b, required edges=8 diff=ff bout=1",
                     n, bus8.diff, bus8.bout);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (bus8.ovf !== 1'b0) begin
            errors++;
            $display("FAIL borrow_wrap_ovf: got %b, required 0", bus8.ovf);
        end
`endif
        step();
        start8(8'h80, 8'h01);
        wait_done8(n);
        checks++;
        if ({n[7:0], bus8.diff, bus8.bout} !== {8'd8, 8'h7F, 1'b0}) begin
            errors++;
            $display("FAIL signed_min: edges=%0d diff=%h bout=%b, required edges=8 diff=7f bout=0",
                     n, bus8.diff, bus8.bout);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (bus8.ovf !== 1'b1) begin
            errors++;
            $display("FAIL signed_min_ovf: got %b, required 1", bus8.ovf);
        end
`endif
        step();
    endtask

    task automatic test_back_to_back();
        int n;
        start8(8'h5A, 8'h23);
        step();
        step();
        bus8.a = 8'hFF;
        bus8.b = 8'hFF;
        bus8.start = 1'b1;
        step();
        bus8.start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if ({bus8.done, bus8.diff, bus8.bout} !== {1'b1, 8'h37, 1'b0}) begin
            errors++;
            $display("FAIL busy_start_ignored: done=%b diff=%h bout=%b, required done=1 diff=37 bout=0",
                     bus8.done, bus8.diff, bus8.bout);
        end
        start8(8'h10, 8'h20);
        checks++;
        if ({bus8.busy, bus8.diff} !== {1'b1, 8'h37}) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b diff=%h, required busy=1 diff=37", bus8.busy, bus8.diff);
        end
        wait_done8(n);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL b2b_spacing: done %0d edges after accept, required 8", n);
        end
        checks++;
        if ({bus8.diff, bus8.bout} !== {8'hF0, 1'b1}) begin
            errors++;
            $display("FAIL b2b_result: diff=%h bout=%b, required diff=f0 bout=1", bus8.diff, bus8.bout);
        end
        step();
    endtask

    task automatic test_reset_midrun();
        int   n;
        logic seen_done;
        start8(8'h3C, 8'h0F);
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        checks++;
        if ({bus8.busy, bus8.done, bus8.diff, bus8.bout} !== 11'd0) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b done=%b diff=%h bout=%b, required all 0",
                     bus8.busy, bus8.done, bus8.diff, bus8.bout);
        end
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin
            errors++;
            $display("FAIL midrun_no_done: activity seen=%b, required 0", seen_done);
        end
        start8(8'h03, 8'h05);
        wait_done8(n);
        checks++;
        if ({n[7:0], bus8.diff, bus8.bout} !== {8'd8, 8'hFE, 1'b1}) begin
            errors++;
            $display("FAIL midrun_recover: edges=%0d diff=%h bout=%b, required edges=8 diff=fe bout=1",
                     n, bus8.diff, bus8.bout);
        end
        step();
    endtask

    task automatic test_sweep4();
        int n;
        int exp_diff;
        int exp_bout;
        int sa_i;
        int sb_i;
        int sdiff;
        for (int av = 0; av < 16; av++) begin
            for (int bv = 0; bv < 16; bv++) begin
                bus4.a = 4'(av);
                bus4.b = 4'(bv);
                bus4.start = 1'b1;
                step();
                bus4.start = 1'b0;
                n = 0;
                for (int i = 0; i < 10; i++) begin
                    step();
                    n++;
                    if (bus4.done === 1'b1) break;
                end
                exp_diff = (av - bv) & 15;
                exp_bout = (av < bv) ? 1 : 0;
                checks++;
                if ({n[3:0], bus4.diff, bus4.bout} !== {4'd4, 4'(exp_diff), exp_bout[0]}) begin
                    errors++;
                    $display("FAIL sweep4 a=%0d b=%0d: edges=%0d diff=%0d bout=%b, required edges=4 diff=%0d bout=%0d",
                             av, bv, n, bus4.diff, bus4.bout, exp_diff, exp_bout);
                end
                sa_i = (av >= 8) ? av - 16 : av;
                sb_i = (bv >= 8) ? bv - 16 : bv;
                sdiff = sa_i - sb_i;
`ifdef SERIAL_SUB_OVF_EN
                checks++;
                if (bus4.ovf !== ((sdiff < -8 || sdiff > 7) ? 1'b1 : 1'b0)) begin
                    errors++;
                    $display("FAIL sweep4_ovf a=%0d b=%0d: got %b, signed diff %0d", av, bv, bus4.ovf, sdiff);
                end
`endif
                step();
            end
        end
    endtask

    initial begin
        bus8.start = 1'b0;
        bus8.a = '0;
        bus8.b = '0;
        bus4.start = 1'b0;
        bus4.a = '0;
        bus4.b = '0;
        test_reset();
        test_basic();
        test_borrow_ovf();
        test_back_to_back();
        test_reset_midrun();
        test_sweep4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
